// File: rtl/paddle_if.sv
// Paddle controller bus: player/AI inputs and registered paddle outputs.
// The game side drives requests; the controller returns position and status.
interface paddle_if #(
   parameter int COORD_W = 10
);
   logic               mode;
   logic               up;
   logic               down;
   logic [COORD_W-1:0] ball_y;
   logic               freeze;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic [3:0]         speed;
   logic               moving;
   logic               at_top;
   logic               at_bottom;

   modport master (
      output mode, up, down, ball_y, freeze,
      input  x, y, speed, moving, at_top, at_bottom
   );

   modport slave (
      input  mode, up, down, ball_y, freeze,
      output x, y, speed, moving, at_top, at_bottom
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle position controller: manual or ball-tracking motion with
// stepped acceleration, screen-limit clamping and a freeze hold.
module paddle_ctrl #(
   parameter int COORD_W     = 10,
   parameter int POS_X       = 20,
   parameter int POS_Y       = 200,
   parameter int Y_MIN       = 0,
   parameter int Y_MAX       = 280,
   parameter int MAX_SPEED   = 4,
   parameter int ACCEL_DIV   = 8,
   parameter int AI_DEADBAND = 4
) (
   input logic   game_clk,
   input logic   rst,
   paddle_if.slave pif
);
   typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
   typedef enum logic [1:0] {REQ_NONE, REQ_UP, REQ_DOWN} req_t;

   localparam int CNT_W = (ACCEL_DIV < 2) ? 1 : $clog2(ACCEL_DIV + 1);
   localparam int EW    = COORD_W + 1;

   localparam logic [COORD_W-1:0] YMIN_C = COORD_W'(Y_MIN);
   localparam logic [COORD_W-1:0] YMAX_C = COORD_W'(Y_MAX);
   localparam logic [3:0]         MAX_C  = 4'(MAX_SPEED);
   localparam logic [CNT_W-1:0]   DIV_C  = CNT_W'(ACCEL_DIV);
   localparam logic [EW-1:0]      DB_C   = EW'(AI_DEADBAND);

   state_t             state_q, state_d;
   logic               dir_q, dir_d;
   logic [3:0]         spd_q, spd_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [COORD_W-1:0] y_q, y_d, x_q;
   req_t               req;
   logic               at_lim;
   logic               req_dn;
   logic [EW-1:0]      y_e, b_e, step_e;

   assign y_e    = {1'b0, y_q};
   assign b_e    = {1'b0, pif.ball_y};
   assign req_dn = (req == REQ_DOWN);

   // Extra coordinate bit keeps the deadband sums from wrapping
   always_comb begin
      req = REQ_NONE;
      if (!pif.mode) begin
         if (pif.up)
            req = REQ_UP;
         else if (pif.down)
            req = REQ_DOWN;
      end else begin
         if (b_e + DB_C < y_e)
            req = REQ_UP;
         else if (b_e > y_e + DB_C)
            req = REQ_DOWN;
      end
   end

   assign at_lim = ((req == REQ_UP) && (y_q == YMIN_C)) ||
                   ((req == REQ_DOWN) && (y_q == YMAX_C));

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      spd_d   = spd_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      step_e  = '0;
      if (!pif.freeze) begin
         if (req == REQ_NONE || at_lim) begin
            state_d = IDLE;
            spd_d   = 4'd0;
            cnt_d   = '0;
         end else if (state_q == IDLE || req_dn != dir_q) begin
            dir_d   = req_dn;
            spd_d   = 4'd1;
            cnt_d   = CNT_W'(1);
            state_d = (MAX_SPEED == 1) ? CRUISE : ACCEL;
         end else if (state_q == ACCEL) begin
            if (cnt_q == DIV_C) begin
               spd_d = spd_q + 4'd1;
               cnt_d = CNT_W'(1);
               if (spd_q + 4'd1 == MAX_C)
                  state_d = CRUISE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end else begin
            spd_d = MAX_C;
         end

         step_e = EW'(spd_d);
         if (state_d != IDLE) begin
            if (!req_dn) begin
               if (y_e - EW'(Y_MIN) < step_e)
                  y_d = YMIN_C;
               else
                  y_d = y_q - COORD_W'(spd_d);
            end else begin
               if (EW'(Y_MAX) - y_e < step_e)
                  y_d = YMAX_C;
               else
                  y_d = y_q + COORD_W'(spd_d);
            end
         end
      end
   end

   always_ff @(posedge game_clk) begin
      if (rst) begin
         state_q <= IDLE;
         dir_q   <= 1'b0;
         spd_q   <= 4'd0;
         cnt_q   <= '0;
         y_q     <= COORD_W'(POS_Y);
         x_q     <= COORD_W'(POS_X);
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         spd_q   <= spd_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
         x_q     <= x_q;
      end
   end

   assign pif.x         = x_q;
   assign pif.y         = y_q;
   assign pif.speed     = spd_q;
   assign pif.moving    = (state_q != IDLE);
   assign pif.at_top    = (y_q == YMIN_C);
   assign pif.at_bottom = (y_q == YMAX_C);
endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Parametrised paddle position controller for the Pong game datapath, successor to the fixed-speed player block. One instance per side; it produces the paddle's top-left coordinate each game tick from either button inputs (manual mode) or the ball's y coordinate (AI mode). Motion accelerates while a direction is held, clamps at configurable screen limits, and can be frozen by the game FSM between points.

## Interface
- COORD_W, 10, width of x/y/ball_y coordinates
- POS_X, 20, fixed paddle x coordinate
- POS_Y, 200, paddle y after reset
- Y_MIN, 0, topmost legal y
- Y_MAX, 280, bottommost legal y (screen height minus paddle height)
- MAX_SPEED, 4, cruise step in pixels/tick, 1..15
- ACCEL_DIV, 8, ticks spent at each speed before stepping up, >=1
- AI_DEADBAND, 4, AI mode: no motion while |ball_y - y| <= this

- game_clk  in  1  game tick clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset; overrides every other input
- mode  in  1  0 = manual (up/down), 1 = AI (track ball_y)
- up  in  1  manual move toward Y_MIN
- down  in  1  manual move toward Y_MAX
- ball_y  in  COORD_W  ball y coordinate, used only when mode=1
- freeze  in  1  hold all state (pause)
- x  out  COORD_W  paddle x, registered
- y  out  COORD_W  paddle y, registered
- speed  out  4  step applied on the last tick (0 when stopped)
- moving  out  1  state != IDLE
- at_top  out  1  combinational, y == Y_MIN
- at_bottom  out  1  combinational, y == Y_MAX

## Operation
- Request each tick: manual: up -> UP, else down -> DOWN, else NONE (up wins when both high). AI: ball_y + AI_DEADBAND < y -> UP; ball_y > y + AI_DEADBAND -> DOWN; else NONE. Comparisons in COORD_W+1 bits, no wrap.
- States: IDLE, ACCEL, CRUISE. Registers: dir, speed, tick counter cnt.
- NONE from any state -> IDLE, speed 0, cnt 0, y unchanged.
- Request at the limit in its direction (UP with y==Y_MIN, DOWN with y==Y_MAX) -> IDLE, speed 0, y unchanged.
- Request from IDLE, or request opposite to dir (reversal) -> ACCEL, dir = request, speed 1, cnt 1; y moves by 1.
- Same request in ACCEL: if cnt == ACCEL_DIV, speed+1, cnt 1; else cnt+1. Reaching MAX_SPEED -> CRUISE. If MAX_SPEED == 1, IDLE goes directly to CRUISE.
- Same request in CRUISE: speed stays MAX_SPEED.
- Step applied on a tick = speed value after that tick's update.
- Clamp: UP with y - Y_MIN < step -> y = Y_MIN; DOWN with Y_MAX - y < step -> y = Y_MAX; state and speed keep their update this tick. The next tick hits the at-limit rule.
- freeze=1 (no rst): y, speed, state, cnt held; requests ignored.
- Mode change mid-motion: no special handling; the new request source applies from that tick.
- x is loaded with POS_X on reset and never changes.

## Timing
- Reset values: x=POS_X, y=POS_Y, speed=0, state IDLE, cnt=0, moving=0. at_top/at_bottom follow y.
- Latency: input sampled at edge N is reflected in y/speed/moving after edge N. No pipeline.
- rst during motion: all values return to reset values at that edge, regardless of freeze.
- y stays within [Y_MIN, Y_MAX] at all times after reset.

## Test plan
- Reset: rst high for 2 ticks -> x=20, y=200, speed=0, moving=0, at_top=0, at_bottom=0.
- Acceleration: manual, hold up from y=200 -> speed 1 for ticks 1-8 (y=192), 2 for 9-16 (y=176), 3 for 17-24 (y=152). Tick 25: speed 4, CRUISE, y=148.
- Wall clamp: hold down from y=200 -> y=280 at tick 32, at_bottom=1. Tick 33: speed 0, moving 0, y stays 280. Also start at y=278 at speed 4 -> clamps to 280.
- Priority/reversal: up+down together -> moves up. Switch to down at speed 3 -> next tick speed 1, y+1. Release -> speed 0 the next tick.
- AI mode: y=200, ball_y=100 -> moves up, accelerating. ball_y=198 -> IDLE, y held. ball_y=260 -> moves down.
- Freeze/reset: freeze at speed 2 for 5 ticks -> y/speed unchanged. Release -> resumes at speed 2 with cnt preserved. rst asserted with freeze=1 -> reset values.
